// File: rtl/fpu_add_pkg.sv
// rtl/fpu_add_pkg.sv - shared widths, constants and FSM encoding for the add/sub issue block
package fpu_add_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_RESP      = 3'd4
  } issue_state_t;

  localparam int FLAG_W         = 5;
  localparam int FLAG_TIMEOUT   = 4;
  localparam int FLAG_NAN       = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_ZERO      = 0;

  localparam logic [63:0] NAN_64 = 64'hFFF8_0000_0000_0000;
  localparam logic [63:0] INF_64 = 64'h7FF0_0000_0000_0000;
  localparam logic [31:0] NAN_32 = 32'hFFC0_0000;
  localparam logic [31:0] INF_32 = 32'h7F80_0000;

  function automatic int exp_bits(input int fw);
    return (fw == 32) ? 8 : 11;
  endfunction

  function automatic int man_bits(input int fw);
    return (fw == 32) ? 23 : 52;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// rtl/fpu_req_fifo.sv - request FIFO, pointers carry a wrap bit to tell full from empty
module fpu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpu_add_issue.sv
// rtl/fpu_add_issue.sv - issue front-end for the add/sub core; FPU_ISSUE_WATCHDOG_EN adds a wait watchdog
module fpu_add_issue
  import fpu_add_pkg::*;
#(
  parameter int FLOAT_WIDTH    = 64,
  parameter int DEPTH          = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [FLOAT_WIDTH-1:0] req_op1,
  input  logic [FLOAT_WIDTH-1:0] req_op2,
  input  logic                   req_sub,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [FLOAT_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  output logic [FLAG_W-1:0]      rsp_flags,
  output logic                   core_start,
  output logic [FLOAT_WIDTH-1:0] core_op1,
  output logic [FLOAT_WIDTH-1:0] core_op2,
  output logic                   core_op_sub,
  input  logic [FLOAT_WIDTH-1:0] core_out,
  input  logic                   core_nan,
  input  logic                   core_overflow,
  input  logic                   core_underflow,
  input  logic                   core_zero,
  input  logic                   core_done
);

  localparam int ENTRY_W = 2 * FLOAT_WIDTH + 1 + TAG_WIDTH;

  issue_state_t state_q, state_d;

  logic [ENTRY_W-1:0]     head;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, capture, wd_fire, load_ops;
  logic [FLOAT_WIDTH-1:0] head_op1, head_op2;
  logic                   head_sub;
  logic [TAG_WIDTH-1:0]   head_tag;

  logic [FLOAT_WIDTH-1:0] rsp_data_q;
  logic [TAG_WIDTH-1:0]   rsp_tag_q;
  logic [3:0]             rsp_core_flags_q;
  logic                   rsp_timeout;

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;
  assign capture   = (state_q == ST_WAIT_HIGH) && (core_done == 1'b1);
  assign pop       = capture || wd_fire;
  assign {head_op1, head_op2, head_sub, head_tag} = head;

  fpu_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_op1, req_op2, req_sub, req_tag}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FPU_ISSUE_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // A timeout only wins when the core has not completed in the same cycle.
  assign wd_fire = ((state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH)) &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) && !capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_q == ST_START) wd_cnt <= '0;
      else if ((state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH)) wd_cnt <= wd_cnt + 1'b1;
      if (capture) rsp_timeout <= 1'b0;
      else if (wd_fire) rsp_timeout <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!fifo_empty) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (core_done == 1'b0) state_d = ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (core_done == 1'b1) state_d = ST_RESP;
      ST_RESP:      if (rsp_ready) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:      state_d = ST_IDLE;
    endcase
    if (wd_fire) state_d = ST_RESP;
  end

  assign load_ops = (state_d == ST_START) && (state_q != ST_START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      core_op1         <= '0;
      core_op2         <= '0;
      core_op_sub      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_tag_q        <= '0;
      rsp_core_flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_ops) begin
        core_op1    <= head_op1;
        core_op2    <= head_op2;
        core_op_sub <= head_sub;
      end
      if (capture) begin
        rsp_data_q       <= core_out;
        rsp_tag_q        <= head_tag;
        rsp_core_flags_q <= {core_nan, core_overflow, core_underflow, core_zero};
      end else if (wd_fire) begin
        rsp_data_q       <= '0;
        rsp_tag_q        <= head_tag;
        rsp_core_flags_q <= '0;
      end
    end
  end

  assign core_start = (state_q == ST_START);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_flags  = {rsp_timeout, rsp_core_flags_q};

endmodule

// File: tb/tb_fpu_add_issue.sv
// tb/tb_fpu_add_issue.sv - self-checking bench with a behavioural 6-stage add/sub core model
`timescale 1ns/1ps
module tb_fpu_add_issue;

  localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] CNAN  = 64'hFFF8_0000_0000_0000;
  localparam int          TMO   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [63:0] req_op1 = '0, req_op2 = '0;
  logic        req_sub = 1'b0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [4:0]  rsp_flags;
  logic        core_start, core_op_sub;
  logic [63:0] core_op1, core_op2, core_out;
  logic        core_nan, core_overflow, core_underflow, core_zero, core_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;
  logic hang = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (core_start) start_cnt <= start_cnt + 1;

  fpu_add_issue #(.FLOAT_WIDTH(64), .DEPTH(4), .TAG_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op1(req_op1), .req_op2(req_op2),
    .req_sub(req_sub), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_flags(rsp_flags),
    .core_start(core_start), .core_op1(core_op1), .core_op2(core_op2), .core_op_sub(core_op_sub),
    .core_out(core_out), .core_nan(core_nan), .core_overflow(core_overflow),
    .core_underflow(core_underflow), .core_zero(core_zero), .core_done(core_done)
  );

  // IEEE double add/sub from real arithmetic: {nan, overflow, underflow, zero, result}
  function automatic logic [67:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic s);
    real ra, rb, rr;
    logic [63:0] r;
    logic [3:0]  f;
    logic        a_nan, b_nan, a_inf, b_inf;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    rr = s ? (ra - rb) : (ra + rb);
    r  = $realtobits(rr);
    f  = 4'b0000;
    a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    a_inf = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
    b_inf = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
    if (a_nan || b_nan) begin
      r = CNAN; f[3] = 1'b1;
    end else if (r[62:52] == 11'h7FF) begin
      if (r[51:0] != 0) begin r = CNAN; f[3] = 1'b1; end
      else if (!a_inf && !b_inf) f[2] = 1'b1;
    end else if (r[62:52] == 11'h000) begin
      if (r[51:0] == 0) f[0] = 1'b1;
      else f[1] = 1'b1;
    end
    return {f, r};
  endfunction

  function automatic logic [63:0] rand_dbl();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'($urandom_range(1000, 1046));
    v[51:32] = 20'($urandom);
    v[31:0]  = $urandom;
    return v;
  endfunction

  // Core model: done drops on start, result and done rise six edges later.
  logic [63:0] c_a, c_b;
  logic        c_s, c_busy;
  int          c_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done <= 1'b1; c_busy <= 1'b0; c_cnt <= 0; core_out <= '0;
      {core_nan, core_overflow, core_underflow, core_zero} <= 4'b0;
    end else if (core_start) begin
      c_a <= core_op1; c_b <= core_op2; c_s <= core_op_sub;
      core_done <= 1'b0; c_busy <= 1'b1; c_cnt <= 0;
    end else if (c_busy && !hang) begin
      if (c_cnt == 5) begin
        {core_nan, core_overflow, core_underflow, core_zero, core_out} <= ref_add(c_a, c_b, c_s);
        core_done <= 1'b1; c_busy <= 1'b0;
      end else c_cnt <= c_cnt + 1;
    end
  end

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic s,
                      input logic [3:0] t, output int edge_no);
    int budget;
    budget = 0;
    req_op1 = a; req_op2 = b; req_sub = s; req_tag = t; req_valid = 1'b1;
    while (!req_ready && budget < 300) begin @(negedge clk); budget++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL push_timeout tag=%0d waited=%0d", t, budget); end
    @(posedge clk);
    @(negedge clk);
    edge_no = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int edge_no);
    int budget;
    budget = 0;
    while (!rsp_valid && budget < limit) begin @(negedge clk); budget++; end
    edge_no = cyc;
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL rsp_timeout waited=%0d", budget); end
  endtask

  task automatic single_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                           input logic [3:0] t, output int lat);
    int pe, re;
    rsp_ready = 1'b1;
    push(a, b, s, t, pe);
    wait_rsp(100, re);
    lat = re - pe;
  endtask

  task automatic finish_rsp();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({rsp_data, rsp_tag, rsp_flags} !== '0) begin errors++;
      $display("FAIL reset_rsp_regs data=%h tag=%h flags=%b exp=0", rsp_data, rsp_tag, rsp_flags); end
    checks++; if ({core_start, core_op1, core_op2, core_op_sub} !== '0) begin errors++;
      $display("FAIL reset_core_ports start=%b op1=%h op2=%h sub=%b exp=0", core_start, core_op1, core_op2, core_op_sub); end
  endtask

  task automatic test_basic();
    int lat, s0;
    s0 = start_cnt;
    single_op(ONE, TWO, 1'b0, 4'd5, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (rsp_data !== 64'h4008_0000_0000_0000) begin errors++; $display("FAIL basic_data got=%h exp=4008000000000000", rsp_data); end
    checks++; if (rsp_flags !== 5'b00000) begin errors++; $display("FAIL basic_flags got=%b exp=00000", rsp_flags); end
    checks++; if (rsp_tag !== 4'd5) begin errors++; $display("FAIL basic_tag got=%0d exp=5", rsp_tag); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start_pulses got=%0d exp=1", start_cnt - s0); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    logic [63:0] a [5];
    logic [63:0] b [5];
    logic        s [5];
    int          pe [5];
    int          first_rsp;
    logic [67:0] e;
    for (int i = 0; i < 5; i++) begin a[i] = rand_dbl(); b[i] = rand_dbl(); s[i] = 1'($urandom_range(0, 1)); end
    rsp_ready = 1'b1;
    first_rsp = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push(a[i], b[i], s[i], 4'(i), pe[i]);
          if (i == 3) begin
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got_ready=%b exp=0", req_ready); end
          end
        end
      end
      begin
        for (int j = 0; j < 5; j++) begin
          int re;
          wait_rsp(200, re);
          if (j == 0) first_rsp = re;
          e = ref_add(a[j], b[j], s[j]);
          checks++; if (rsp_tag !== 4'(j)) begin errors++; $display("FAIL b2b_tag got=%0d exp=%0d", rsp_tag, j); end
          checks++; if ({rsp_flags, rsp_data} !== {1'b0, e}) begin errors++;
            $display("FAIL b2b_data idx=%0d got=%b/%h exp=%b/%h", j, rsp_flags, rsp_data, {1'b0, e[67:64]}, e[63:0]); end
          finish_rsp();
        end
      end
    join
    checks++; if (pe[4] !== first_rsp + 1) begin errors++;
      $display("FAIL b2b_fifth_accept got_edge=%0d exp_edge=%0d", pe[4], first_rsp + 1); end
  endtask

  task automatic test_stall();
    logic [63:0] a0, b0, a1, b1, d0;
    logic [3:0]  t0;
    logic [67:0] e;
    int pe, re, bad_hold, bad_start;
    a0 = rand_dbl(); b0 = rand_dbl(); a1 = rand_dbl(); b1 = rand_dbl();
    rsp_ready = 1'b0;
    push(a0, b0, 1'b1, 4'd10, pe);
    push(a1, b1, 1'b0, 4'd11, pe);
    wait_rsp(100, re);
    d0 = rsp_data; t0 = rsp_tag;
    e = ref_add(a0, b0, 1'b1);
    checks++; if (d0 !== e[63:0] || t0 !== 4'd10) begin errors++;
      $display("FAIL stall_first got=%h/%0d exp=%h/10", d0, t0, e[63:0]); end
    bad_hold = 0; bad_start = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_tag !== t0) bad_hold++;
      if (core_start !== 1'b0) bad_start++;
    end
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL stall_hold unstable_cycles=%0d exp=0", bad_hold); end
    checks++; if (bad_start !== 0) begin errors++; $display("FAIL stall_no_start start_cycles=%0d exp=0", bad_start); end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (core_start !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL stall_restart start=%b valid=%b exp=1/0", core_start, rsp_valid); end
    wait_rsp(100, re);
    e = ref_add(a1, b1, 1'b0);
    checks++; if (rsp_data !== e[63:0] || rsp_tag !== 4'd11) begin errors++;
      $display("FAIL stall_second got=%h/%0d exp=%h/11", rsp_data, rsp_tag, e[63:0]); end
    rsp_ready = 1'b1;
    finish_rsp();
  endtask

  task automatic test_sub_zero();
    int lat;
    single_op(ONE, ONE, 1'b1, 4'd2, lat);
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL subzero_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_flags !== 5'b00001) begin errors++; $display("FAIL subzero_flags got=%b exp=00001", rsp_flags); end
    finish_rsp();
  endtask

  task automatic test_nan();
    int lat;
    single_op(64'h7FF8_0000_0000_0000, ONE, 1'b0, 4'd7, lat);
    checks++; if (rsp_data !== CNAN) begin errors++; $display("FAIL nan_data got=%h exp=%h", rsp_data, CNAN); end
    checks++; if (rsp_flags !== 5'b01000) begin errors++; $display("FAIL nan_flags got=%b exp=01000", rsp_flags); end
    finish_rsp();
  endtask

  task automatic test_random_backpressure();
    localparam int N = 12;
    logic [63:0] a [N];
    logic [63:0] b [N];
    logic        s [N];
    logic [67:0] e;
    int idx, budget;
    for (int i = 0; i < N; i++) begin a[i] = rand_dbl(); b[i] = rand_dbl(); s[i] = 1'($urandom_range(0, 1)); end
    fork
      begin
        for (int i = 0; i < N; i++) begin
          int pe;
          push(a[i], b[i], s[i], 4'(i), pe);
        end
      end
      begin
        idx = 0; budget = 0;
        while (idx < N && budget < 3000) begin
          rsp_ready = 1'($urandom_range(0, 1));
          if (rsp_valid && rsp_ready) begin
            e = ref_add(a[idx], b[idx], s[idx]);
            checks++; if ({rsp_tag, rsp_flags, rsp_data} !== {4'(idx), 1'b0, e}) begin errors++;
              $display("FAIL rand_rsp idx=%0d got=%0d/%b/%h exp=%0d/%b/%h", idx, rsp_tag, rsp_flags, rsp_data,
                       idx, {1'b0, e[67:64]}, e[63:0]); end
            idx++;
          end
          @(negedge clk);
          budget++;
        end
        checks++; if (idx !== N) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", idx, N); end
      end
    join
    rsp_ready = 1'b1;
  endtask

  task automatic test_watchdog_reset();
    int pe, bad;
    rsp_ready = 1'b1;
    hang = 1'b1;
`ifdef FPU_ISSUE_WATCHDOG_EN
    begin
      int re;
      push(ONE, TWO, 1'b0, 4'd9, pe);
      wait_rsp(100, re);
      checks++; if (re - pe !== 2 + TMO) begin errors++; $display("FAIL wd_latency got=%0d exp=%0d", re - pe, 2 + TMO); end
      checks++; if (rsp_flags !== 5'b10000 || rsp_data !== 64'h0 || rsp_tag !== 4'd9) begin errors++;
        $display("FAIL wd_rsp flags=%b data=%h tag=%0d exp=10000/0/9", rsp_flags, rsp_data, rsp_tag); end
      finish_rsp();
    end
`endif
    push(ONE, TWO, 1'b0, 4'd3, pe);
    push(TWO, ONE, 1'b1, 4'd4, pe);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL midreset_handshake ready=%b valid=%b exp=1/0", req_ready, rsp_valid); end
    checks++; if ({rsp_data, rsp_tag, rsp_flags, core_start, core_op1, core_op2, core_op_sub} !== '0) begin errors++;
      $display("FAIL midreset_outputs data=%h tag=%h flags=%b start=%b op1=%h op2=%h sub=%b", rsp_data, rsp_tag,
               rsp_flags, core_start, core_op1, core_op2, core_op_sub); end
    @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || core_start !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_fifo_empty active_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_sub_zero();
    test_nan();
    test_random_backpressure();
    test_watchdog_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "bench time limit");
  end

endmodule
